// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential BRAM fetch into a 2-entry {pc, instr} buffer with redirect flush.
// Define INSTR_FETCH_PERF_EN to add the perf_fetched / perf_stall counter outputs.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    output logic                  bram_re,
    input  logic [DATA_WIDTH-1:0] bram_do,
    input  logic                  bram_do_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH+1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH+1:0] redirect_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);
    localparam int              PW               = ADDR_WIDTH + 2;
    localparam logic [PW-1:0]   PC_ALIGN_MASK    = ~PW'(3);
    localparam logic [PW-1:0]   RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           fetch_pc_reg, fetch_pc_next;
    logic                    inflight_reg;
    logic [PW-1:0]           inflight_pc_reg;
    logic [PW-1:0]           fifo_pc_reg    [2];
    logic [DATA_WIDTH-1:0]   fifo_instr_reg [2];
    logic                    rd_ptr_reg, wr_ptr_reg;
    logic [1:0]              count_reg;
    logic                    push, pop, flush;
    logic [2:0]              occupancy;

    assign out_valid    = (count_reg != 2'd0);
    assign pop          = out_valid && out_ready;
    assign out_instr    = out_valid ? fifo_instr_reg[rd_ptr_reg] : '0;
    assign out_pc       = out_valid ? fifo_pc_reg[rd_ptr_reg] : '0;
    assign bram_rd_addr = fetch_pc_reg[PW-1:2];

    // A slot freed by this cycle's pop is already available to a new request,
    // which is what keeps the stream at one instruction per cycle.
    assign occupancy = {1'b0, count_reg} - {2'b00, pop} + {2'b00, inflight_reg};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= BOOT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        bram_re       = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        if (redirect_valid) begin
            // Redirect beats any push; the response arriving now is simply dropped.
            flush         = 1'b1;
            fetch_pc_next = redirect_pc & PC_ALIGN_MASK;
            state_next    = inflight_reg ? FLUSH : RUN;
        end else begin
            case (state_reg)
                BOOT:  state_next = RUN;
                RUN: begin
                    push = inflight_reg && bram_do_valid;
                    if (occupancy < 3'd2) begin
                        bram_re       = 1'b1;
                        fetch_pc_next = fetch_pc_reg + PW'(4);
                    end
                end
                FLUSH:   state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_reg    <= RESET_PC_ALIGNED;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            inflight_reg <= bram_re;
            if (bram_re) inflight_pc_reg <= fetch_pc_reg;
            if (flush) begin
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
                count_reg  <= 2'd0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Buffer storage needs no reset: outputs are masked while the buffer is empty.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge CLK) begin
            if (push && (wr_ptr_reg == 1'(gi))) begin
                fifo_pc_reg[gi]    <= inflight_pc_reg;
                fifo_instr_reg[gi] <= bram_do;
            end
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetched_reg, perf_stall_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            perf_fetched_reg <= perf_fetched_reg + 32'(pop);
            perf_stall_reg   <= perf_stall_reg + 32'(out_valid && !out_ready);
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stream-level model (expected pc sequence + memory image) plus literal checks.
module tb_instr_fetch_unit;
    localparam int            AW     = 10;
    localparam int            DW     = 32;
    localparam int            PW     = AW + 2;
    localparam logic [PW-1:0] RST_PC = 12'h100;

    logic          CLK, RST;
    logic [AW-1:0] bram_rd_addr;
    logic          bram_re;
    logic [DW-1:0] bram_do;
    logic          bram_do_valid;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          inject;

    logic [3:0]    s_addr;
    logic          s_re, s_do_valid, s_valid;
    logic [31:0]   s_do, s_instr;
    logic [5:0]    s_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]   perf_fetched, perf_stall, s_perf_fetched, s_perf_stall;
`endif

    logic [DW-1:0] mem       [1024];
    logic [31:0]   small_mem [16];

    int tests = 0;
    int fails = 0;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) u_dut (
        .CLK(CLK), .RST(RST),
        .bram_rd_addr(bram_rd_addr), .bram_re(bram_re),
        .bram_do(bram_do), .bram_do_valid(bram_do_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef INSTR_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    instr_fetch_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RESET_PC(6'h3C)) u_small (
        .CLK(CLK), .RST(RST),
        .bram_rd_addr(s_addr), .bram_re(s_re),
        .bram_do(s_do), .bram_do_valid(s_do_valid),
        .out_valid(s_valid), .out_ready(1'b1),
        .out_instr(s_instr), .out_pc(s_pc),
        .redirect_valid(1'b0), .redirect_pc(6'h00)
`ifdef INSTR_FETCH_PERF_EN
        , .perf_fetched(s_perf_fetched), .perf_stall(s_perf_stall)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle BRAM models; inject forces a response with nothing in flight.
    always @(posedge CLK) begin
        bram_do_valid <= bram_re | inject;
        bram_do       <= mem[bram_rd_addr];
        s_do_valid    <= s_re;
        s_do          <= small_mem[s_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        @(negedge CLK);
        while (!out_valid && n < 10) begin
            step();
            @(negedge CLK);
            n++;
        end
        check("wait_valid", out_valid, 1);
    endtask

    task automatic do_reset();
        RST = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; inject = 1'b0;
        @(negedge CLK);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Stream model: every accepted word must be the next sequential pc and its memory word.
    initial begin : model
        logic [PW-1:0] exp_pc, held_pc;
        logic [DW-1:0] held_instr;
        logic          prev_stall;
        int            outstanding;
        exp_pc = RST_PC; held_pc = '0; held_instr = '0; prev_stall = 1'b0; outstanding = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_pc = RST_PC; outstanding = 0; prev_stall = 1'b0;
                check("rst_valid", out_valid, 0);
                check("rst_re", bram_re, 0);
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_pc", out_pc, held_pc);
                    check("hold_instr", out_instr, held_instr);
                end
                if (out_valid && out_ready) begin
                    $display("[TB] pop pc=0x%03h instr=0x%08h", out_pc, out_instr);
                    check("model_pc", out_pc, exp_pc);
                    check("model_instr", out_instr, mem[exp_pc[PW-1:2]]);
                    exp_pc = exp_pc + 12'd4;
                end
                if (redirect_valid) begin
                    check("redirect_no_re", bram_re, 0);
                    exp_pc      = redirect_pc & ~12'h003;
                    outstanding = 0;
                    prev_stall  = 1'b0;
                end else begin
                    outstanding = outstanding + int'(bram_re) - int'(out_valid && out_ready);
                    check("credit_le2", outstanding <= 2, 1);
                    prev_stall = out_valid && !out_ready;
                    held_pc    = out_pc;
                    held_instr = out_instr;
                end
            end
        end
    end

    logic [5:0]  s_pc_q    [2];
    logic [31:0] s_instr_q [2];
    int          s_seen = 0;

    initial begin : small_capture
        forever begin
            @(negedge CLK);
            if (!RST && s_valid && s_seen < 2) begin
                s_pc_q[s_seen]    = s_pc;
                s_instr_q[s_seen] = s_instr;
                s_seen++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : directed
        int          n, reqs;
        logic [31:0] pat;
        RST = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inject = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
        for (int i = 0; i < 16; i++)   small_mem[i] = 32'h5000_0000 + 32'(i);

        // Sequential stream from RESET_PC with out_ready held high
        do_reset();
        out_ready = 1'b1;
        @(negedge CLK); check("boot_valid", out_valid, 0); check("boot_re", bram_re, 0);
        step(); @(negedge CLK); check("first_re", bram_re, 1); check("first_addr", bram_rd_addr, 10'h040);
        step(); @(negedge CLK); check("c2_valid", out_valid, 0); check("c2_addr", bram_rd_addr, 10'h041);
        for (int k = 0; k < 4; k++) begin
            step(); @(negedge CLK);
            check("seq_valid", out_valid, 1);
            check("seq_pc", out_pc, 12'h100 + 12'(4 * k));
            check("seq_instr", out_instr, 32'hC0DE_0040 + 32'(k));
        end

        // Back-pressure for five cycles, with a stray response while full
        do_reset();
        reqs = 0;
        for (int c = 0; c < 8; c++) begin
            inject = (c == 4);
            @(negedge CLK);
            reqs += int'(bram_re);
            if (c >= 3) begin
                check("stall_valid", out_valid, 1);
                check("stall_instr", out_instr, 32'hC0DE_0040);
            end
            step();
        end
        inject = 1'b0;
        check("stall_reqs_le2", reqs <= 2, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("release_valid", out_valid, 1);
            check("release_pc", out_pc, 12'h100 + 12'(4 * k));
            check("release_instr", out_instr, 32'hC0DE_0040 + 32'(k));
            step();
        end

        // Redirect with a request in flight (misaligned target)
        redirect_valid = 1'b1; redirect_pc = 12'h203;
        @(negedge CLK); check("redir_re", bram_re, 0);
        step(); redirect_valid = 1'b0;
        @(negedge CLK); check("flush_valid", out_valid, 0); check("flush_re", bram_re, 0);
        step();
        wait_valid(n);
        check("redir_latency", n, 2);
        check("redir_pc", out_pc, 12'h200);
        check("redir_instr", out_instr, 32'hC0DE_0080);

        // Second redirect while in FLUSH
        step(); redirect_valid = 1'b1; redirect_pc = 12'h300;
        @(negedge CLK);
        step(); redirect_pc = 12'h400;
        @(negedge CLK); check("flush_redir_re", bram_re, 0);
        step(); redirect_valid = 1'b0;
        wait_valid(n);
        check("flush_redir_latency", n, 2);
        check("flush_redir_pc", out_pc, 12'h400);
        check("flush_redir_instr", out_instr, 32'hC0DE_0100);

        // PC wrap at the top of the address space
        step(); redirect_valid = 1'b1; redirect_pc = 12'hFFE;
        @(negedge CLK);
        step(); redirect_valid = 1'b0;
        @(negedge CLK);
        step();
        wait_valid(n);
        check("wrap_pc_top", out_pc, 12'hFFC);
        check("wrap_instr_top", out_instr, 32'hC0DE_03FF);
        step(); @(negedge CLK);
        check("wrap_valid", out_valid, 1);
        check("wrap_pc_zero", out_pc, 12'h000);
        check("wrap_instr_zero", out_instr, 32'hC0DE_0000);

        // Irregular out_ready with a redirect in the middle; the model checks every cycle
        pat = 32'b1011_0011_1000_1111_0101_1100_0110_1101;
        for (int c = 0; c < 32; c++) begin
            step();
            out_ready      = pat[c];
            redirect_valid = (c == 20);
            redirect_pc    = 12'h052;
            @(negedge CLK);
        end

        // Asynchronous reset with the buffer full
        step(); redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (4) step();
        @(negedge CLK); check("prefull_valid", out_valid, 1);
        step();
        #2 RST = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_re", bram_re, 0);
        check("async_rst_pc", out_pc, 0);
        @(posedge CLK);
        #1 RST = 1'b0; out_ready = 1'b1;
        wait_valid(n);
        check("restart_latency", n, 3);
        check("restart_pc", out_pc, 12'h100);
        check("restart_instr", out_instr, 32'hC0DE_0040);

`ifdef INSTR_FETCH_PERF_EN
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            out_ready = (c >= 6 && c <= 9);
            @(negedge CLK);
            if (c == 0) begin
                check("perf_fetched_rst", perf_fetched, 0);
                check("perf_stall_rst", perf_stall, 0);
            end
            if (c == 10) begin
                check("perf_fetched", perf_fetched, 4);
                check("perf_stall", perf_stall, 3);
            end
            step();
        end
`endif

        // Narrow instance starting at the last word of its address space
        check("small_seen", s_seen, 2);
        check("small_pc0", s_pc_q[0], 6'h3C);
        check("small_instr0", s_instr_q[0], 32'h5000_000F);
        check("small_pc1", s_pc_q[1], 6'h00);
        check("small_instr1", s_instr_q[1], 32'h5000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the BRAM word-address width; PC width is ADDR_WIDTH+2 (byte address).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the byte-address PC loaded at reset.
REQ-004 Ports SHALL be:
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- bram_rd_addr  out  ADDR_WIDTH  word read address, PC[ADDR_WIDTH+1:2].
- bram_re  out  1  read request strobe.
- bram_do  in  DATA_WIDTH  read data.
- bram_do_valid  in  1  response valid; one cycle after bram_re.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_instr  out  DATA_WIDTH  instruction word.
- out_pc  out  ADDR_WIDTH+2  byte PC of out_instr.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_WIDTH+2  redirect target.
REQ-005 The clock port is CLK and the reset port is RST; RST is asynchronous and active-high, with one clock domain.

Function
REQ-006 Fetch SHALL keep fetch_pc, a 2-entry FIFO of {pc, instr}, a 1-bit in-flight flag, and FSM states BOOT, RUN, FLUSH.
REQ-007 BOOT: no request; next edge -> RUN.
REQ-008 RUN: bram_re=1 iff (FIFO count + in-flight) < 2 and redirect_valid=0; on issue, fetch_pc += 4 and the request's pc is tagged into the in-flight slot.
REQ-009 Read latency SHALL be 1 cycle: data with bram_do_valid=1 is written to the FIFO at the next rising edge, in issue order.
REQ-010 Steady state with out_ready=1 SHALL sustain one instruction per cycle; first out_valid is 3 cycles after RST deasserts (BOOT, issue, capture).
REQ-011 out_valid = FIFO non-empty; out_instr/out_pc show FIFO head; pop on out_valid & out_ready.
REQ-012 out_instr/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 FIFO full with out_ready=0: no new request; the credit rule guarantees that no response is lost.
REQ-014 Simultaneous push and pop SHALL keep count unchanged.
REQ-015 redirect_valid=1: FIFO flushed and fetch_pc <= {redirect_pc[ADDR_WIDTH+1:2], 2'b00} at that edge. Next state: FLUSH if a request is in flight, else RUN. No request in the redirect cycle.
REQ-016 FLUSH: the arriving response SHALL be discarded; bram_re=0; next edge -> RUN.
REQ-017 redirect_valid with out_valid & out_ready in the same cycle: the handshake completes, then the flush applies; a redirect SHALL win over any push.
REQ-018 Redirect during FLUSH SHALL reload fetch_pc and stay in FLUSH for one more cycle only if a new request is in flight, otherwise -> RUN.
REQ-019 fetch_pc SHALL wrap modulo 2^(ADDR_WIDTH+2); 0x...FFC + 4 -> 0.
REQ-020 A bram_do_valid with no request in flight SHALL be ignored.

Reset
REQ-021 RST SHALL asynchronously force: state=BOOT, fetch_pc=RESET_PC with bits[1:0]=0, FIFO empty, in-flight=0, bram_re=0, out_valid=0, out_instr=0, out_pc=0.
REQ-022 Reset mid-operation SHALL discard FIFO contents and any in-flight response.

Configuration
REQ-023 Macro INSTR_FETCH_PERF_EN SHALL, when defined, add outputs perf_fetched (32 bits, count of instructions popped) and perf_stall (32 bits, cycles with out_valid=1 and out_ready=0). Both reset to 0 and wrap at 2^32.
REQ-024 Without INSTR_FETCH_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-025 RESET_PC=0x100, out_ready=1, BRAM words 0x40..0x43 = A..D -> out_valid from cycle 3; out_pc 0x100,0x104,0x108,0x10C with A,B,C,D on consecutive cycles.
REQ-026 out_ready=0 for 5 cycles after first out_valid -> at most 2 requests issued; out_instr stays A; release -> A,B,C in order with no gap or loss.
REQ-027 redirect_pc=0x203 while in flight -> in-flight word dropped; next out_pc=0x200; no stale pc emitted.
REQ-028 ADDR_WIDTH=4, PC=0x3C -> outputs 0x3C then 0x00.
REQ-029 RST asserted mid-stream with FIFO full -> out_valid=0 and bram_re=0 immediately; restart at RESET_PC.
REQ-030 With INSTR_FETCH_PERF_EN: 4 pops and 3 stall cycles -> perf_fetched=4, perf_stall=3.
